// File: rtl/sobel_column_builder.sv
// Raster-to-column converter: turns a row-major grayscale pixel stream into
// 3-pixel vertical columns {row r, row r-1, row r-2} for the Sobel stage.
// Two line buffers hold the previous rows. Each buffer has one write port and
// one registered read port that prefetches the entry for the next column to be
// popped. IMG_WIDTH must be at least 2 so that the prefetch address never
// equals the address being written in the same cycle.
module sobel_column_builder #(
  parameter int unsigned IMG_WIDTH  = 720,
  parameter int unsigned IMG_HEIGHT = 540,
  parameter int unsigned PIX_DWIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [PIX_DWIDTH-1:0]   in_dout,
  input  logic                    in_empty,
  output logic                    in_rd_en,
  output logic [3*PIX_DWIDTH-1:0] out_din,
  input  logic                    out_full,
  output logic                    out_wr_en,
  output logic                    frame_done
);

  localparam int unsigned ColW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned RowW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  typedef enum logic [0:0] {
    StFill,
    StRun
  } state_e;

  state_e                  r_state;
  state_e                  w_state_next;
  logic [ColW-1:0]         r_col;
  logic [ColW-1:0]         w_col_next;
  logic [RowW-1:0]         r_row;
  logic [RowW-1:0]         w_row_next;
  logic                    w_pop;
  logic                    w_wr;
  logic                    w_last_col;
  logic                    w_last_row;

  logic [PIX_DWIDTH-1:0]   r_lb0 [IMG_WIDTH];
  logic [PIX_DWIDTH-1:0]   r_lb1 [IMG_WIDTH];
  logic [PIX_DWIDTH-1:0]   r_rd0;
  logic [PIX_DWIDTH-1:0]   r_rd1;

  logic [3*PIX_DWIDTH-1:0] r_s1_data;
  logic                    r_s1_valid;
  logic                    r_s1_last;

  // A pop needs reset released, data upstream, and room in S1 (empty or draining).
  assign w_pop      = reset & ~in_empty & (~r_s1_valid | ~out_full);
  assign w_wr       = r_s1_valid & ~out_full;
  assign w_last_col = (r_col == ColW'(IMG_WIDTH - 1));
  assign w_last_row = (r_row == RowW'(IMG_HEIGHT - 1));

  assign in_rd_en   = w_pop;
  assign out_wr_en  = w_wr;
  assign out_din    = r_s1_data;
  assign frame_done = w_wr & r_s1_last;

  // Next-state logic: position counters advance per pop; FILL covers rows 0 and 1.
  always_comb begin
    w_col_next   = r_col;
    w_row_next   = r_row;
    w_state_next = r_state;
    if (w_pop) begin
      if (w_last_col) begin
        w_col_next = '0;
        w_row_next = w_last_row ? '0 : r_row + RowW'(1);
      end else begin
        w_col_next = r_col + ColW'(1);
      end
    end
    unique case (r_state)
      StFill: begin
        if (w_pop && w_last_col && (r_row == RowW'(1))) begin
          w_state_next = StRun;
        end
      end
      StRun: begin
        if (w_pop && w_last_col && w_last_row) begin
          w_state_next = StFill;
        end
      end
      default: w_state_next = StFill;
    endcase
  end

  // State and position registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= StFill;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_next;
      r_col   <= w_col_next;
      r_row   <= w_row_next;
    end
  end

  // Line buffer writes: shift the column down one row and store the new pixel.
  always_ff @(posedge clock) begin
    if (w_pop) begin
      r_lb0[r_col] <= r_rd1;
      r_lb1[r_col] <= in_dout;
    end
  end

  // Registered read port: prefetch the entries for the column popped next.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd0 <= '0;
      r_rd1 <= '0;
    end else begin
      r_rd0 <= r_lb0[w_col_next];
      r_rd1 <= r_lb1[w_col_next];
    end
  end

  // Output stage S1: loads on every RUN pop, holds under backpressure, clears when drained.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1_data  <= '0;
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
    end else if (w_pop && (r_state == StRun)) begin
      r_s1_data  <= {in_dout, r_rd1, r_rd0};
      r_s1_valid <= 1'b1;
      r_s1_last  <= w_last_col & w_last_row;
    end else if (w_wr) begin
      r_s1_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sobel_column_builder.sv
// Scoreboard bench for sobel_column_builder on a 4x4 image.
// The driver pushes the expected column for every pop of a row-2/3 pixel;
// a forked monitor pops and compares on every out_wr_en.
module tb_sobel_column_builder;

  localparam int unsigned W = 4;
  localparam int unsigned H = 4;
  localparam int unsigned D = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic [D-1:0]   in_dout;
  logic           in_empty;
  logic           in_rd_en;
  logic [3*D-1:0] out_din;
  logic           out_full;
  logic           out_wr_en;
  logic           frame_done;

  always #5 clock = ~clock;

  sobel_column_builder #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .PIX_DWIDTH(D)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_dout   (in_dout),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en),
    .out_din   (out_din),
    .out_full  (out_full),
    .out_wr_en (out_wr_en),
    .frame_done(frame_done)
  );

  typedef struct packed {
    logic [3*D-1:0] data;
    logic           last;
  } exp_t;

  exp_t           sb_q[$];
  logic [3*D-1:0] wr_log[$];
  logic [3*D-1:0] ref_words[8];
  int             errors = 0;
  int             checks = 0;
  int             idx = 0;
  int             wr_total = 0;
  int             done_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected column for pixel value v: {v, v-4, v-8} when v sits in row 2 or 3.
  task automatic push_model(input int v);
    exp_t e;
    int   f;
    f = v % 16;
    if (f / 4 >= 2) begin
      e.data = {8'(v), 8'(v - 4), 8'(v - 8)};
      e.last = (f == 15);
      sb_q.push_back(e);
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clock);
      #3;
      if (reset) begin
        check("done_implies_write", 32'(frame_done & ~out_wr_en), 0);
        if (in_empty) check("rd_en_while_empty", 32'(in_rd_en), 0);
        if (out_wr_en) begin
          if (sb_q.size() == 0) begin
            check("unexpected_write", 32'(out_wr_en), 0);
          end else begin
            e = sb_q.pop_front();
            check("col_data", 32'(out_din), 32'(e.data));
            check("frame_done", 32'(frame_done), 32'(e.last));
          end
          wr_log.push_back(out_din);
          wr_total++;
          if (frame_done) done_total++;
        end
      end
    end
  endtask

  // One cycle of upstream FIFO model: present pixel idx, count the pop if taken.
  task automatic step(input logic emp, input logic full);
    @(negedge clock);
    in_empty = emp;
    out_full = full;
    in_dout  = 8'(idx);
    #1;
    if (in_rd_en && !in_empty) begin
      push_model(idx);
      idx++;
    end
  endtask

  // mode 0: free-running, 1: in_empty toggles, 2: 5-cycle out_full hold on 3rd column.
  task automatic run(input int npix, input int mode);
    int   cyc;
    int   hold;
    bit   held;
    logic emp;
    logic full;
    cyc  = 0;
    hold = 0;
    held = 0;
    while ((idx < npix || sb_q.size() != 0) && cyc < 400) begin
      emp  = (idx >= npix) || (mode == 1 && (cyc % 2) == 1);
      full = (hold > 0);
      step(emp, full);
      if (full) begin
        check("hold_data", 32'(out_din), 32'h0A0602);
        check("hold_wr_en", 32'(out_wr_en), 0);
        check("hold_rd_en", 32'(in_rd_en), 0);
        hold--;
      end
      if (mode == 2 && !held && idx == 11) begin
        held = 1;
        hold = 5;
      end
      cyc++;
    end
    if (mode == 2) check("hold_seen", 32'(held), 1);
    repeat (3) step(1'b1, 1'b0);
    check("scoreboard_drained", 32'(sb_q.size()), 0);
  endtask

  // Compare a finished run against the reference frame words.
  task automatic verify_frame(input string tag, input int base, input int dbase,
                              input int nw, input int nd);
    check({tag, "_writes"}, 32'(wr_total - base), 32'(nw));
    check({tag, "_frame_done_count"}, 32'(done_total - dbase), 32'(nd));
    for (int i = 0; i < 8; i++) begin
      if (base + i < wr_log.size()) check({tag, "_word"}, 32'(wr_log[base + i]), 32'(ref_words[i]));
    end
  endtask

  initial begin
    int base;
    int dbase;
    reset    = 1'b1;
    in_empty = 1'b1;
    out_full = 1'b0;
    in_dout  = '0;
    fork
      monitor_loop();
    join_none

    #1 reset = 1'b0;
    #1;
    check("reset_rd_en", 32'(in_rd_en), 0);
    check("reset_wr_en", 32'(out_wr_en), 0);
    check("reset_out_din", 32'(out_din), 0);
    check("reset_frame_done", 32'(frame_done), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Free-running frame; hand-computed first and last columns.
    base  = wr_total;
    dbase = done_total;
    idx   = 0;
    run(16, 0);
    check("s1_writes", 32'(wr_total - base), 8);
    check("s1_frame_done_count", 32'(done_total - dbase), 1);
    if (wr_log.size() >= base + 8) begin
      check("s1_first", 32'(wr_log[base]), 32'h080400);
      check("s1_last", 32'(wr_log[base + 7]), 32'h0F0B07);
    end
    for (int r = 2; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        ref_words[(r - 2) * 4 + c] = {8'(r * 4 + c), 8'(r * 4 + c - 4), 8'(r * 4 + c - 8)};
      end
    end

    // Upstream FIFO empty every other cycle.
    base  = wr_total;
    dbase = done_total;
    idx   = 0;
    run(16, 1);
    verify_frame("empty_toggle", base, dbase, 8, 1);

    // Backpressure on the 3rd column.
    base  = wr_total;
    dbase = done_total;
    idx   = 0;
    run(16, 2);
    verify_frame("backpressure", base, dbase, 8, 1);

    // Two frames back to back.
    base  = wr_total;
    dbase = done_total;
    idx   = 0;
    run(32, 0);
    verify_frame("two_frames", base, dbase, 16, 2);
    if (wr_log.size() >= base + 9) check("frame2_first", 32'(wr_log[base + 8]), 32'h181410);

    // Reset after pixel 9, then replay a full frame.
    idx = 0;
    run(10, 0);
    check("pre_reset_out_din", 32'(out_din), 32'h090501);
    reset    = 1'b0;
    in_empty = 1'b0;
    #1;
    check("midreset_rd_en", 32'(in_rd_en), 0);
    check("midreset_wr_en", 32'(out_wr_en), 0);
    check("midreset_out_din", 32'(out_din), 0);
    check("midreset_frame_done", 32'(frame_done), 0);
    in_empty = 1'b1;
    sb_q.delete();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    base  = wr_total;
    dbase = done_total;
    idx   = 0;
    run(16, 0);
    verify_frame("after_reset", base, dbase, 8, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

endmodule
